// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle CPU control sequencer: FSM states,
// instruction classes, opcode/opext fields and datapath mux selects.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC_R,
    ST_EXEC_I,
    ST_MEM_RD,
    ST_MEM_WR,
    ST_BRANCH,
    ST_JUMP,
    ST_JAL,
    ST_NOP_ADV,
    ST_FAULT
  } state_e;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_I,
    CLS_LOAD,
    CLS_STOR,
    CLS_JAL,
    CLS_JCOND,
    CLS_BCOND,
    CLS_NOP
  } instr_cls_e;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ANDI  = 4'b0001;
  localparam logic [3:0] OP_ORI   = 4'b0010;
  localparam logic [3:0] OP_XORI  = 4'b0011;
  localparam logic [3:0] OP_MEMJ  = 4'b0100;
  localparam logic [3:0] OP_ADDI  = 4'b0101;
  localparam logic [3:0] OP_SHIFT = 4'b1000;
  localparam logic [3:0] OP_SUBI  = 4'b1001;
  localparam logic [3:0] OP_CMPI  = 4'b1011;
  localparam logic [3:0] OP_BCOND = 4'b1100;
  localparam logic [3:0] OP_MOVI  = 4'b1101;
  localparam logic [3:0] OP_LUI   = 4'b1111;

  localparam logic [3:0] EXT_LOAD      = 4'b0000;
  localparam logic [3:0] EXT_STOR      = 4'b0100;
  localparam logic [3:0] EXT_JAL       = 4'b1000;
  localparam logic [3:0] EXT_JCOND     = 4'b1100;
  localparam logic [3:0] EXT_SHIFT_REG = 4'b0100;
  localparam logic [3:0] EXT_CMP       = 4'b1011;
  localparam logic [3:0] EXT_MOV       = 4'b1101;

  localparam logic [1:0] PC_INC  = 2'd0;
  localparam logic [1:0] PC_DISP = 2'd1;
  localparam logic [1:0] PC_REG  = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC1 = 2'd2;

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Combinational instruction-class decode from opcode/opext, plus the
// flag-write and register-write qualifiers used by the execute states.
module cpu_ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic [3:0] opext,
  output instr_cls_e cls,
  output logic       flags_we,
  output logic       reg_we
);

  always_comb begin
    cls      = CLS_NOP;
    flags_we = 1'b1;
    reg_we   = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        cls = CLS_R;
        if (opext == EXT_MOV) flags_we = 1'b0;
        if (opext == EXT_CMP) reg_we = 1'b0;
      end
      OP_ANDI, OP_ORI, OP_XORI, OP_ADDI, OP_SUBI, OP_CMPI, OP_MOVI, OP_LUI: begin
        cls = CLS_I;
        if (opcode == OP_MOVI || opcode == OP_LUI) flags_we = 1'b0;
        if (opcode == OP_CMPI) reg_we = 1'b0;
      end
      OP_SHIFT: begin
        // Register-form shift takes its amount from Rsrc, so it uses the R path.
        cls      = (opext == EXT_SHIFT_REG) ? CLS_R : CLS_I;
        flags_we = 1'b0;
      end
      OP_MEMJ: begin
        case (opext)
          EXT_LOAD:  cls = CLS_LOAD;
          EXT_STOR:  cls = CLS_STOR;
          EXT_JAL:   cls = CLS_JAL;
          EXT_JCOND: cls = CLS_JCOND;
          default:   cls = CLS_NOP;
        endcase
      end
      OP_BCOND: cls = CLS_BCOND;
      default:  cls = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control sequencer for the 16-bit datapath.
// Optional retired-instruction counter enabled by defining CPU_PERF_CNT_EN.
module cpu_ctrl_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       opcode,
  input  logic [3:0]       opext,
  input  logic             cond_true,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic [1:0]       pc_sel,
  output logic             ir_en,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             reg_we,
  output logic [1:0]       wb_sel,
  output logic             alu_srcb,
  output logic             flags_we,
  output logic             fault,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam logic [7:0] WAIT_LIMIT = 8'(MEM_WAIT_MAX - 1);

  state_e     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  instr_cls_e dec_cls;
  logic       dec_flags_we;
  logic       dec_reg_we;

  cpu_ctrl_decode u_decode (
    .opcode   (opcode),
    .opext    (opext),
    .cls      (dec_cls),
    .flags_we (dec_flags_we),
    .reg_we   (dec_reg_we)
  );

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    pc_en      = 1'b0;
    pc_sel     = PC_INC;
    ir_en      = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    addr_sel   = 1'b0;
    reg_we     = 1'b0;
    wb_sel     = WB_ALU;
    alu_srcb   = 1'b0;
    flags_we   = 1'b0;
    fault      = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_en   = 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        case (dec_cls)
          CLS_R:     state_d = ST_EXEC_R;
          CLS_I:     state_d = ST_EXEC_I;
          CLS_LOAD:  state_d = ST_MEM_RD;
          CLS_STOR:  state_d = ST_MEM_WR;
          CLS_BCOND: state_d = ST_BRANCH;
          CLS_JCOND: state_d = ST_JUMP;
          CLS_JAL:   state_d = ST_JAL;
          default:   state_d = ST_NOP_ADV;
        endcase
      end
      ST_EXEC_R, ST_EXEC_I: begin
        reg_we   = dec_reg_we;
        flags_we = dec_flags_we;
        alu_srcb = (state_q == ST_EXEC_I);
        pc_en    = 1'b1;
        state_d  = ST_FETCH;
      end
      ST_MEM_RD: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        if (mem_ready) begin
          reg_we  = 1'b1;
          wb_sel  = WB_MEM;
          pc_en   = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_MEM_WR: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        addr_sel = 1'b1;
        if (mem_ready) begin
          pc_en   = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_BRANCH: begin
        pc_en   = 1'b1;
        pc_sel  = cond_true ? PC_DISP : PC_INC;
        state_d = ST_FETCH;
      end
      ST_JUMP: begin
        pc_en   = 1'b1;
        pc_sel  = cond_true ? PC_REG : PC_INC;
        state_d = ST_FETCH;
      end
      ST_JAL: begin
        reg_we  = 1'b1;
        wb_sel  = WB_PC1;
        pc_en   = 1'b1;
        pc_sel  = PC_REG;
        state_d = ST_FETCH;
      end
      ST_NOP_ADV: begin
        pc_en   = 1'b1;
        state_d = ST_FETCH;
      end
      ST_FAULT: fault = 1'b1;
      default:  state_d = ST_FETCH;
    endcase

    // Timeout: the cycle that would bring the wait count to MEM_WAIT_MAX faults.
    if (mem_req && !mem_ready) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
      if (wait_cnt_q == WAIT_LIMIT) state_d = ST_FAULT;
    end
    if (state_d != state_q) wait_cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_FETCH;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

`ifdef CPU_PERF_CNT_EN
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;

  always_comb begin
    instr_cnt_d = instr_cnt_q;
    if (pc_en) instr_cnt_d = instr_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) instr_cnt_q <= '0;
    else       instr_cnt_q <= instr_cnt_d;
  end

  assign instr_cnt = instr_cnt_q;
`else
  assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Self-checking bench for cpu_ctrl_fsm: directed scenarios plus randomized
// instruction streams compared cycle by cycle against a per-instruction model.
module tb_cpu_ctrl_fsm;

  localparam int WAITMAX = 15;
  localparam int CW      = 4;

  typedef struct packed {
    logic       pc_en;
    logic [1:0] pc_sel;
    logic       ir_en;
    logic       mem_req;
    logic       mem_we;
    logic       addr_sel;
    logic       reg_we;
    logic [1:0] wb_sel;
    logic       alu_srcb;
    logic       flags_we;
    logic       fault;
  } ctl_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [3:0]    opcode = '0;
  logic [3:0]    opext = '0;
  logic          cond_true = 1'b0;
  logic          mem_ready = 1'b0;
  logic          pc_en, ir_en, mem_req, mem_we, addr_sel, reg_we, alu_srcb, flags_we, fault;
  logic [1:0]    pc_sel, wb_sel;
  logic [CW-1:0] instr_cnt;
  ctl_t          obs;

  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned model_cnt = 0;

  cpu_ctrl_fsm #(.MEM_WAIT_MAX(WAITMAX), .CNT_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .opcode    (opcode),
    .opext     (opext),
    .cond_true (cond_true),
    .mem_ready (mem_ready),
    .pc_en     (pc_en),
    .pc_sel    (pc_sel),
    .ir_en     (ir_en),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .addr_sel  (addr_sel),
    .reg_we    (reg_we),
    .wb_sel    (wb_sel),
    .alu_srcb  (alu_srcb),
    .flags_we  (flags_we),
    .fault     (fault),
    .instr_cnt (instr_cnt)
  );

  assign obs = {pc_en, pc_sel, ir_en, mem_req, mem_we, addr_sel, reg_we, wb_sel,
                alu_srcb, flags_we, fault};

  always #5 clk = ~clk;

  // One clock cycle: drive at the falling edge, check 1ns later, update the
  // retired-instruction model for the edge that follows.
  task automatic run_cycle(input logic rst, input logic rdy, input ctl_t exp, input string tag);
    logic [CW-1:0] exp_cnt;
    @(negedge clk);
    reset     = rst;
    mem_ready = rdy;
    #1;
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: controls got %h want %h", tag, obs, exp);
    end
`ifdef CPU_PERF_CNT_EN
    exp_cnt = CW'(model_cnt);
`else
    exp_cnt = '0;
`endif
    n_tests++;
    assert (instr_cnt === exp_cnt) else begin
      n_fail++;
      $error("FAIL %s-cnt: instr_cnt got %0d want %0d", tag, instr_cnt, exp_cnt);
    end
    if (rst) model_cnt = 0;
    else if (exp.pc_en) model_cnt = (model_cnt + 1) % (1 << CW);
  endtask

  task automatic fetch_decode(input logic [3:0] op, input logic [3:0] ext, input logic cond,
                              input int fw, input string tag);
    ctl_t e;
    opcode    = op;
    opext     = ext;
    cond_true = cond;
    for (int i = 0; i < fw; i++) begin
      e = '0; e.mem_req = 1'b1;
      run_cycle(1'b0, 1'b0, e, {tag, "-fetchwait"});
    end
    e = '0; e.mem_req = 1'b1; e.ir_en = 1'b1;
    run_cycle(1'b0, 1'b1, e, {tag, "-fetch"});
    e = '0;
    run_cycle(1'b0, 1'($urandom_range(0, 1)), e, {tag, "-decode"});
  endtask

  // Expected behaviour of one whole instruction, derived from its class.
  task automatic run_instr(input logic [3:0] op, input logic [3:0] ext, input logic cond,
                           input int fw, input int mw, input string tag);
    ctl_t e;
    logic is_shift, alu_r, alu_i;
    is_shift = (op == 4'd8);
    alu_r    = (op == 4'd0) || (is_shift && ext == 4'd4);
    alu_i    = (op inside {4'd1, 4'd2, 4'd3, 4'd5, 4'd9, 4'd11, 4'd13, 4'd15}) ||
               (is_shift && ext != 4'd4);
    fetch_decode(op, ext, cond, fw, tag);
    e = '0;
    if (alu_r || alu_i) begin
      e.pc_en    = 1'b1;
      e.alu_srcb = alu_i;
      e.flags_we = !(is_shift || (op == 4'd0 && ext == 4'd13) || op == 4'd13 || op == 4'd15);
      e.reg_we   = !((op == 4'd0 && ext == 4'd11) || op == 4'd11);
      run_cycle(1'b0, 1'($urandom_range(0, 1)), e, {tag, "-exec"});
    end else if (op == 4'd4 && (ext == 4'd0 || ext == 4'd4)) begin
      e.mem_req  = 1'b1;
      e.addr_sel = 1'b1;
      e.mem_we   = (ext == 4'd4);
      for (int i = 0; i < mw; i++) run_cycle(1'b0, 1'b0, e, {tag, "-memwait"});
      e.pc_en = 1'b1;
      if (ext == 4'd0) begin
        e.reg_we = 1'b1;
        e.wb_sel = 2'd1;
      end
      run_cycle(1'b0, 1'b1, e, {tag, "-memdone"});
    end else begin
      e.pc_en = 1'b1;
      if (op == 4'd12) e.pc_sel = cond ? 2'd1 : 2'd0;
      else if (op == 4'd4 && ext == 4'd12) e.pc_sel = cond ? 2'd2 : 2'd0;
      else if (op == 4'd4 && ext == 4'd8) begin
        e.pc_sel = 2'd2;
        e.reg_we = 1'b1;
        e.wb_sel = 2'd2;
      end
      run_cycle(1'b0, 1'($urandom_range(0, 1)), e, {tag, "-exec"});
    end
  endtask

  initial begin
    ctl_t e;
    logic [3:0] ext_pool [6];
    logic [3:0] rop, rext;
    ext_pool = '{4'd0, 4'd4, 4'd8, 4'd11, 4'd12, 4'd13};

    repeat (2) @(posedge clk);

    // ADD with zero-wait memory; first fetch cycle doubles as the reset check.
    run_instr(4'b0000, 4'b0101, 1'b0, 0, 0, "add");
    run_instr(4'b0100, 4'b0000, 1'b0, 0, 3, "load-wait3");
    run_instr(4'b1100, 4'b0000, 1'b1, 0, 0, "bcond-t");
    run_instr(4'b1100, 4'b0000, 1'b0, 0, 0, "bcond-f");
    run_instr(4'b0100, 4'b1000, 1'b0, 1, 0, "jal");
    run_instr(4'b0100, 4'b1100, 1'b1, 0, 0, "jcond-t");
    run_instr(4'b0000, 4'b1011, 1'b0, 0, 0, "cmp");
    run_instr(4'b1101, 4'b0000, 1'b0, 0, 0, "movi");
    run_instr(4'b1000, 4'b0100, 1'b0, 0, 0, "shift-reg");
    run_instr(4'b1000, 4'b0001, 1'b0, 0, 0, "shift-imm");

    // Store that never completes: times out into FAULT, ignores mem_ready there.
    fetch_decode(4'b0100, 4'b0100, 1'b0, 0, "stor-to");
    e = '0; e.mem_req = 1'b1; e.mem_we = 1'b1; e.addr_sel = 1'b1;
    for (int i = 0; i < WAITMAX; i++) run_cycle(1'b0, 1'b0, e, "stor-to-wait");
    e = '0; e.fault = 1'b1;
    for (int i = 0; i < 3; i++) run_cycle(1'b0, 1'(i % 2), e, "fault-hold");
    run_cycle(1'b1, 1'b0, e, "fault-reset");
    run_instr(4'b0000, 4'b0001, 1'b0, 0, 0, "after-fault");

    // Reset in the middle of a write access.
    fetch_decode(4'b0100, 4'b0100, 1'b0, 0, "stor-rst");
    e = '0; e.mem_req = 1'b1; e.mem_we = 1'b1; e.addr_sel = 1'b1;
    run_cycle(1'b0, 1'b0, e, "stor-rst-wait");
    run_cycle(1'b1, 1'b0, e, "stor-rst-assert");

    // 17 NOPs from a cleared counter; the first fetch waits one cycle.
    for (int i = 0; i < 17; i++) run_instr(4'b0110, 4'b0000, 1'b0, (i == 0) ? 1 : 0, 0, "nop");

    for (int n = 0; n < 60; n++) begin
      rop  = 4'($urandom_range(0, 15));
      rext = ($urandom_range(0, 1) == 1) ? ext_pool[$urandom_range(0, 5)]
                                         : 4'($urandom_range(0, 15));
      run_instr(rop, rext, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                $urandom_range(0, 3), "rand");
    end
    run_instr(4'b0110, 4'b0000, 1'b0, 0, 0, "final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
